// File: rtl/cnn_tile_engine.sv
// Output-stationary CNN tile engine: TM output lanes accumulate TN input channels per
// cycle over a KxK window, one output pixel at a time, streamed out with valid/ready.
module cnn_tile_engine #(
  parameter int DW   = 8,
  parameter int ACCW = 24,
  parameter int N    = 4,
  parameter int M    = 4,
  parameter int K    = 3,
  parameter int R    = 4,
  parameter int C    = 4,
  parameter int S    = 1,
  parameter int TN   = 2,
  parameter int TM   = 2,
  localparam int IR       = (R - 1) * S + K,
  localparam int IC       = (C - 1) * S + K,
  localparam int FM_DEPTH = N * IR * IC,
  localparam int W_DEPTH  = M * N * K * K,
  localparam int AW       = $clog2((FM_DEPTH > W_DEPTH) ? FM_DEPTH : W_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 start,
  input  logic                 relu_en,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TM*ACCW-1:0]   out_data
);

  localparam int NT  = N / TN;
  localparam int MT  = M / TM;
  localparam int KCW = (K > 1) ? $clog2(K) : 1;
  localparam int TIW = (NT > 1) ? $clog2(NT) : 1;
  localparam int TOW = (MT > 1) ? $clog2(MT) : 1;
  localparam int RW  = (R > 1) ? $clog2(R) : 1;
  localparam int CW  = (C > 1) ? $clog2(C) : 1;

  if ((N % TN) != 0 || (M % TM) != 0) begin : g_bad_tiling
    $error("cnn_tile_engine: N must be a multiple of TN and M a multiple of TM");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, EMIT, FIN} state_t;
  state_t state_reg, state_next;

  logic signed [DW-1:0]   fm_mem [FM_DEPTH];
  logic signed [DW-1:0]   w_mem  [W_DEPTH];
  logic signed [DW-1:0]   fm_rd  [TN];
  logic signed [DW-1:0]   w_rd   [TM][TN];
  logic [AW-1:0]          fm_addr [TN];
  logic [AW-1:0]          w_addr  [TM][TN];
  logic signed [ACCW-1:0] acc      [TM];
  logic signed [ACCW-1:0] lane_sum [TM];

  logic [KCW-1:0] j, i;
  logic [TIW-1:0] ti;
  logic [TOW-1:0] to;
  logic [RW-1:0]  r;
  logic [CW-1:0]  c;

  logic pv;             // read registers hold a product set to fold in this cycle
  logic out_valid_reg;
  logic relu_q;
  logic tap_last, beat_last, accept, launch, fm_ok, w_ok;

  assign tap_last  = (j == KCW'(K - 1)) && (i == KCW'(K - 1)) && (ti == TIW'(NT - 1));
  assign beat_last = (c == CW'(C - 1)) && (r == RW'(R - 1)) && (to == TOW'(MT - 1));
  assign accept    = out_valid_reg && out_ready;
  assign launch    = (state_reg == IDLE) && start;
  assign fm_ok     = {1'b0, wr_addr} < (AW + 1)'(FM_DEPTH);
  assign w_ok      = {1'b0, wr_addr} < (AW + 1)'(W_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = COMPUTE;
      COMPUTE: begin
        busy = 1'b1;
        if (tap_last) state_next = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (accept) state_next = beat_last ? FIN : COMPUTE;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffers are only writable while the engine is parked.
  always_ff @(posedge clk) begin
    if (wr_en && state_reg == IDLE) begin
      if (!wr_sel && fm_ok) fm_mem[wr_addr] <= wr_data;
      if (wr_sel && w_ok)   w_mem[wr_addr]  <= wr_data;
    end
  end

  always_comb begin
    for (int u = 0; u < TN; u++) begin
      fm_addr[u] = AW'((int'(ti) * TN + u) * IR * IC + (int'(r) * S + int'(i)) * IC
                       + int'(c) * S + int'(j));
      for (int t = 0; t < TM; t++) begin
        w_addr[t][u] = AW'((int'(to) * TM + t) * N * K * K + (int'(ti) * TN + u) * K * K
                           + int'(i) * K + int'(j));
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int u = 0; u < TN; u++) begin
      fm_rd[u] <= fm_mem[fm_addr[u]];
      for (int t = 0; t < TM; t++) w_rd[t][u] <= w_mem[w_addr[t][u]];
    end
  end

  always_comb begin
    logic signed [2*DW-1:0] prod;
    prod = '0;
    for (int t = 0; t < TM; t++) begin
      lane_sum[t] = acc[t];
      for (int u = 0; u < TN; u++) begin
        prod        = (2*DW)'(fm_rd[u]) * (2*DW)'(w_rd[t][u]);
        lane_sum[t] = lane_sum[t] + ACCW'(prod);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < TM; t++) acc[t] <= '0;
    end else if (launch || accept) begin
      for (int t = 0; t < TM; t++) acc[t] <= '0;
    end else if (pv) begin
      for (int t = 0; t < TM; t++) acc[t] <= lane_sum[t];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv            <= 1'b0;
      out_valid_reg <= 1'b0;
      relu_q        <= 1'b0;
      j  <= '0;
      i  <= '0;
      ti <= '0;
      to <= '0;
      r  <= '0;
      c  <= '0;
    end else begin
      pv <= (state_reg == COMPUTE);
      // The last product lands during the first EMIT cycle, so valid follows one cycle later.
      if (state_reg == EMIT && pv) out_valid_reg <= 1'b1;
      else if (accept)             out_valid_reg <= 1'b0;
      if (launch) begin
        relu_q <= relu_en;
        j  <= '0;
        i  <= '0;
        ti <= '0;
        to <= '0;
        r  <= '0;
        c  <= '0;
      end else if (state_reg == COMPUTE) begin
        if (j == KCW'(K - 1)) begin
          j <= '0;
          if (i == KCW'(K - 1)) begin
            i  <= '0;
            ti <= (ti == TIW'(NT - 1)) ? '0 : ti + 1'b1;
          end else begin
            i <= i + 1'b1;
          end
        end else begin
          j <= j + 1'b1;
        end
      end else if (accept) begin
        if (c == CW'(C - 1)) begin
          c <= '0;
          if (r == RW'(R - 1)) begin
            r  <= '0;
            to <= (to == TOW'(MT - 1)) ? '0 : to + 1'b1;
          end else begin
            r <= r + 1'b1;
          end
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;

  for (genvar gi = 0; gi < TM; gi++) begin : g_lane
    assign out_data[gi*ACCW +: ACCW] = !out_valid_reg ? '0 :
                                       (relu_q && acc[gi][ACCW-1]) ? '0 : acc[gi];
  end

endmodule

// File: tb/tb_cnn_tile_engine.sv
// Bench for cnn_tile_engine: a convolution model over 3-D/4-D arrays predicts every
// beat; a negedge monitor checks beats, hold stability, latency and the done pulse.
module tb_cnn_tile_engine;
  localparam int DW = 8, ACCW = 24, N = 4, M = 4, K = 3, R = 4, C = 4, S = 1, TN = 2, TM = 2;
  localparam int IR = (R - 1) * S + K;
  localparam int IC = (C - 1) * S + K;
  localparam int AW = 8;
  localparam int NBEATS = (M / TM) * R * C;
  localparam int LAT = (N / TN) * K * K + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0, wr_sel = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic signed [DW-1:0] wr_data = '0;
  logic start = 1'b0, relu_en = 1'b0;
  logic busy, done, out_valid;
  logic out_ready;
  logic [TM*ACCW-1:0] out_data;

  cnn_tile_engine #(.DW(DW), .ACCW(ACCW), .N(N), .M(M), .K(K), .R(R), .C(C), .S(S),
                    .TN(TN), .TM(TM)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int fm3 [N][IR][IC];
  int w4  [M][N][K][K];
  logic [TM*ACCW-1:0] expq [$];
  int beats_acc = 0, done_cnt = 0, job_base = 0, stall = 0, bp_mode = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic signed [ACCW-1:0] model_lane(int m, int r, int c, bit relu);
    longint s;
    logic signed [ACCW-1:0] v;
    s = 0;
    for (int n = 0; n < N; n++)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          s += longint'(fm3[n][r*S+i][c*S+j]) * longint'(w4[m][n][i][j]);
    v = s[ACCW-1:0];
    if (relu && v < 0) v = '0;
    return v;
  endfunction

  task automatic check_int(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic build_expected(bit relu);
    logic [TM*ACCW-1:0] vec;
    expq.delete();
    for (int to = 0; to < M / TM; to++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          for (int t = 0; t < TM; t++) vec[t*ACCW +: ACCW] = model_lane(to * TM + t, r, c, relu);
          expq.push_back(vec);
        end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(int fv, int wv);
    foreach (fm3[n, y, x]) fm3[n][y][x] = fv;
    foreach (w4[m, n, i, j]) w4[m][n][i][j] = wv;
  endtask

  task automatic fill_rand();
    foreach (fm3[n, y, x]) fm3[n][y][x] = int'($urandom_range(0, 255)) - 128;
    foreach (w4[m, n, i, j]) w4[m][n][i][j] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic load();
    for (int n = 0; n < N; n++)
      for (int y = 0; y < IR; y++)
        for (int x = 0; x < IC; x++) begin
          wr_en = 1'b1; wr_sel = 1'b0;
          wr_addr = AW'(n * IR * IC + y * IC + x);
          wr_data = DW'(fm3[n][y][x]);
          tick();
        end
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) begin
            wr_en = 1'b1; wr_sel = 1'b1;
            wr_addr = AW'(m * N * K * K + n * K * K + i * K + j);
            wr_data = DW'(w4[m][n][i][j]);
            tick();
          end
    wr_en = 1'b0;
  endtask

  // mode 0: ready always; 1: stall beat 3 for five cycles; 2: random ready
  task automatic run_job(bit relu, bit disturb, int mode);
    int d0;
    bit seen;
    build_expected(relu);
    job_base = beats_acc;
    d0 = done_cnt;
    stall = 0;
    bp_mode = mode;
    relu_en = relu;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (disturb) begin
        start   = 1'($urandom_range(0, 1));
        relu_en = 1'($urandom_range(0, 1));
        wr_en   = 1'b1;
        wr_sel  = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, 255));
        wr_data = DW'($urandom_range(0, 255));
      end
      tick();
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    wr_en = 1'b0;
    if (!seen) check_int("job_timeout", 0, 1);
    tick();
    check_int("beats_per_job", beats_acc - job_base, NBEATS);
    check_int("leftover_expected", expq.size(), 0);
    check_int("done_pulses", done_cnt - d0, 1);
    if (mode == 1) check_int("stall_cycles", stall, 5);
    bp_mode = 0;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: if (out_valid && (beats_acc - job_base) == 2 && stall < 5) begin
             out_ready = 1'b0;
             stall++;
           end else out_ready = 1'b1;
        2: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  bit prev_valid = 0, prev_ready = 0, prev_done = 0, ref_ok = 0;
  logic [TM*ACCW-1:0] prev_data = '0;
  int ref_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0; prev_ready = 0; prev_done = 0; ref_ok = 0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check_int("hold_valid", out_valid, 1);
        total++;
        if (out_data !== prev_data) begin
          bad++;
          $display("FAIL hold_data: got %h, expected %h", out_data, prev_data);
        end
      end
      if (out_valid && !prev_valid && ref_ok) begin
        check_int("valid_latency", cyc - ref_cyc, LAT);
        ref_ok = 0;
      end
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got %h, expected no beat", out_data);
        end else begin
          if (out_data !== expq[0]) begin
            bad++;
            $display("FAIL beat%0d: got %h, expected %h", beats_acc - job_base, out_data, expq[0]);
          end
          void'(expq.pop_front());
        end
        beats_acc++;
        ref_cyc = cyc + 1;
        ref_ok = 1;
      end
      if (start && !busy && !done) begin
        ref_cyc = cyc + 1;
        ref_ok = 1;
      end
      if (done) begin
        check_int("done_after_last_beat", expq.size(), 0);
        check_int("busy_low_in_done", busy, 0);
        check_int("done_single_cycle", prev_done, 0);
        done_cnt++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_done  = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_busy", busy, 0);
    check_int("reset_done", done, 0);
    check_int("reset_out_valid", out_valid, 0);
    check_int("reset_out_data", longint'(out_data), 0);
    reset = 1'b0;
    tick();

    fill_const(1, 1);
    load();
    check_int("model_ones", model_lane(0, 0, 0, 0), 36);
    run_job(0, 0, 0);

    fill_const(1, -1);
    load();
    check_int("model_neg", model_lane(3, 2, 1, 0), -36);
    run_job(0, 0, 0);
    check_int("model_neg_relu", model_lane(1, 3, 3, 1), 0);
    run_job(1, 0, 0);

    fill_const(127, 127);
    load();
    check_int("model_max", model_lane(2, 1, 2, 0), 580644);
    run_job(0, 0, 0);

    fill_rand();
    load();
    run_job(0, 0, 1);

    fill_rand();
    load();
    run_job(1, 1, 2);

    fill_const(1, 1);
    load();
    expq.delete();
    relu_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    check_int("midrun_reset_busy", busy, 0);
    check_int("midrun_reset_done", done, 0);
    check_int("midrun_reset_out_valid", out_valid, 0);
    check_int("midrun_reset_out_data", longint'(out_data), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    fill_rand();
    load();
    run_job(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_tile_engine.md
CNN_TILE_ENGINE -- requirements
Module: cnn_tile_engine

Interface
REQ-001 SHALL have parameter DW, default 8, signed fixed-point data and weight width.
REQ-002 SHALL have parameter ACCW, default 24, signed accumulator and output lane width.
REQ-003 SHALL have parameters N / M, default 4 / 4, input / output channel counts.
REQ-004 SHALL have parameter K, default 3, square kernel size.
REQ-005 SHALL have parameters R / C, default 4 / 4, output rows / cols; S, default 1, stride.
REQ-006 SHALL have parameters TN / TM, default 2 / 2, input / output channel tile sizes; IR=(R-1)*S+K and IC=(C-1)*S+K are input rows / cols.
REQ-007 SHALL have port clk, input, 1, the only clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port wr_en, input, 1, buffer write strobe.
REQ-010 SHALL have port wr_sel, input, 1, target buffer: 0 = feature map, 1 = weights.
REQ-011 SHALL have port wr_addr, input, clog2(max(N*IR*IC, M*N*K*K)), buffer address.
REQ-012 SHALL have port wr_data, input, DW, signed write data.
REQ-013 SHALL have ports start / relu_en, input, 1 each, start pulse / ReLU mode.
REQ-014 SHALL have ports busy / done, output, 1 each, engine active / one-cycle completion pulse.
REQ-015 SHALL have ports out_valid / out_ready, output / input, 1 each, result stream handshake.
REQ-016 SHALL have port out_data, output, TM*ACCW, lane t in bits [t*ACCW +: ACCW] = output channel to*TM+t.

Function
REQ-017 SHALL hold internal buffers: fm address n*IR*IC + y*IC + x; weight address m*N*K*K + n*K*K + i*K + j.
REQ-018 SHALL perform writes only in IDLE; writes with busy=1 or an out-of-range address SHALL be ignored.
REQ-019 SHALL implement states IDLE, COMPUTE, EMIT and FIN.
REQ-020 SHALL leave IDLE for COMPUTE on start=1, latch relu_en, clear all TM accumulators and set busy=1; start outside IDLE SHALL be ignored.
REQ-021 SHALL, in each COMPUTE cycle, add TM*TN products fm[ti*TN+u][r*S+i][c*S+j] * w[to*TM+t][ti*TN+u][i][j] into lane t, with sign-extended 2*DW products and ACCW two's-complement wrap.
REQ-022 SHALL step counters j, then i, then ti, so a pixel takes exactly T=(N/TN)*K*K COMPUTE cycles, then enter EMIT.
REQ-023 SHALL raise out_valid exactly T+1 cycles after the start edge for the first pixel, and T+1 cycles after each accepted beat for later pixels.
REQ-024 SHALL, in EMIT, drive out_valid=1 and out_data=accumulators (each lane clamped to 0 if negative and relu_en latched); both stay stable until out_ready=1.
REQ-025 SHALL, on the out_valid and out_ready edge, advance c, then r, then to; clear accumulators; return to COMPUTE, or to FIN after the last of (M/TM)*R*C beats.
REQ-026 SHALL, in FIN, pulse done=1 for one cycle, drop busy in that cycle and return to IDLE.
REQ-027 SHALL, at elaboration, fail if N%TN != 0 or M%TM != 0.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-COMPUTE or mid-EMIT, go immediately to IDLE with busy=0, done=0, out_valid=0, out_data=0, counters and accumulators 0 and relu latch 0.
REQ-029 SHALL leave buffer contents undefined after reset; the bench reloads them before start.

Verification
REQ-030 SHALL pass: defaults, all fm=1 and weights=1, relu_en=0, out_ready=1 -> first out_valid 19 cycles after start, 32 beats, every lane 36, done pulse after the last beat.
REQ-031 SHALL pass: fm=1, weights=-1 -> lanes -36 with relu_en=0 and 0 with relu_en=1.
REQ-032 SHALL pass: fm=127, weights=127 -> every lane 580644 (no wrap at ACCW=24).
REQ-033 SHALL pass: out_ready held low 5 cycles on beat 3 -> out_valid and out_data stable throughout, no beat lost or duplicated.
REQ-034 SHALL pass: start pulses and writes during busy -> ignored, results unchanged.
REQ-035 SHALL pass: reset asserted mid-COMPUTE -> all outputs 0 on the same cycle; a fresh start then gives correct results.
